writeback_arbiter: RTL
======================

Name: writeback_arbiter

Overview:
- Single write-port arbiter sitting directly upstream of the CPU register file; drives its iRegWrite/iWriteRegister/iWriteData.
- Merges two result sources:
  - The main pipeline writeback: fixed latency, always accepted, highest priority.
  - A long-latency unit (mul/div): valid/ready handshake, results parked in a small FIFO until a free write slot.
- Squashes stale parked results when the pipeline writes the same rd.
- Exports a pending-rd mask for hazard/stall logic.

Parameters:
- DEPTH, 2, number of parked long-latency entries; legal 2..8.
- PTRW, 1, pointer width = clog2(DEPTH); must be consistent with DEPTH.

Ports:
- iCLK  in  1  clock; all state updates on rising edge.
- iRST_N  in  1  synchronous reset, active-low.
- iPipeValid  in  1  pipeline writeback request this cycle.
- iPipeRd  in  5  pipeline destination register.
- iPipeData  in  32  pipeline write data.
- iLongValid  in  1  long-latency result offered.
- iLongRd  in  5  long-latency destination register.
- iLongData  in  32  long-latency result.
- oLongReady  out  1  arbiter can accept a long-latency result this cycle.
- oRegWrite  out  1  register-file write enable (registered).
- oWriteRegister  out  5  register-file write address (registered).
- oWriteData  out  32  register-file write data (registered).
- oPendingMask  out  32  bit r = 1 iff a live parked entry targets rd r.

Behaviour:
- Reset (iRST_N=0 at a rising edge):
  - oRegWrite=0, oWriteRegister=0, oWriteData=0.
  - FIFO emptied: count=0, pointers=0, all live bits cleared.
  - oPendingMask=0.
  - oLongReady=0 while iRST_N=0.
  - Reset mid-operation discards all parked entries; no write is issued for them.
- x0 filter:
  - Pipeline request with rd=0 is treated as no request.
  - Long-latency transfer with rd=0 completes the handshake but is not enqueued.
- Handshake:
  - oLongReady = iRST_N && (count < DEPTH); combinational from state only, never from iLongValid.
  - Transfer occurs when iLongValid && oLongReady at a rising edge.
  - Source holds rd/data stable while valid && !ready.
- Output slot arbitration, once per cycle, result registered to outputs at the next edge:
  - Priority 1, pipeline: if pipeline request (rd≠0), outputs take the pipeline rd/data with oRegWrite=1. The FIFO head is not popped.
  - Priority 2, FIFO head: else if count>0, pop the head. If the head is live, outputs take its rd/data with oRegWrite=1; if killed, oRegWrite=0.
  - Otherwise oRegWrite=0; rd/data outputs hold their previous values.
- Latency:
  - Pipeline to register-file write: 1 cycle.
  - Long-latency result to write: minimum 2 cycles (enqueue, then pop).
- Simultaneous push and pop in the same cycle is legal; count is unchanged.
  - Push into a full FIFO is impossible because ready=0.
- WAW squash:
  - When the pipeline writes rd=r, every live FIFO entry with rd=r is marked killed in that cycle.
  - An entry pushed in the same cycle with rd=r is newer and stays live.
- Killed entries still occupy a slot until popped.
- oPendingMask:
  - OR over live entries of one-hot(rd).
  - Updated at the same edge as push/pop/kill.
  - Two live entries with the same rd both contribute to the same bit.
- Pointer wrap-around: modulo DEPTH; count width holds 0..DEPTH.

Test Plan:
- Reset: hold iRST_N=0 for 2 cycles with iLongValid=1 -> oLongReady=0, oRegWrite=0, oPendingMask=0, nothing enqueued.
- Pipeline write: pipe rd=5, data=0xDEADBEEF -> next cycle oRegWrite=1, oWriteRegister=5, oWriteData=0xDEADBEEF; pipe rd=0 -> oRegWrite=0.
- Long-latency path, idle pipeline: rd=7, data=0x12345678 -> oPendingMask=0x80 after push; write rd=7 one cycle later; mask returns to 0.
- Fill and backpressure: pipeline busy every cycle with rd=1, push rd=3 then rd=4 -> oLongReady=0 after 2 pushes. Release pipeline -> writes rd=3 then rd=4 in order, oLongReady=1 after first pop.
- WAW squash: park rd=9 (0xAAAA), then pipe writes rd=9 (0xBBBB) -> bit 9 of mask clears; the later pop of the killed entry gives oRegWrite=0; register 9 ends at 0xBBBB.
- Mid-operation reset and wrap: DEPTH=2, run 5 push/pop pairs to wrap pointers, then park an entry and assert reset -> no write of the parked entry; normal operation resumes after iRST_N=1.

Source files
------------

// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback always wins; long-latency
// results are parked in a small FIFO and drained into idle write slots.
module writeback_arbiter #(
  parameter int DEPTH = 2,
  parameter int PTRW  = 1
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iPipeValid,
  input  logic [4:0]  iPipeRd,
  input  logic [31:0] iPipeData,
  input  logic        iLongValid,
  input  logic [4:0]  iLongRd,
  input  logic [31:0] iLongData,
  output logic        oLongReady,
  output logic        oRegWrite,
  output logic [4:0]  oWriteRegister,
  output logic [31:0] oWriteData,
  output logic [31:0] oPendingMask
);

  localparam logic [PTRW:0]   C_DEPTH = (PTRW + 1)'(DEPTH);
  localparam logic [PTRW-1:0] C_LAST  = PTRW'(DEPTH - 1);

  logic [PTRW-1:0] r_wr_ptr;
  logic [PTRW-1:0] r_rd_ptr;
  logic [PTRW:0]   r_count;
  logic [4:0]      r_ent_rd   [DEPTH];
  logic [31:0]     r_ent_data [DEPTH];
  logic            r_live     [DEPTH];

  logic            w_pipe_req;
  logic            w_push;
  logic            w_pop;
  logic            w_head_live;
  logic [PTRW-1:0] w_wr_inc;
  logic [PTRW-1:0] w_rd_inc;
  logic [31:0]     w_mask;

  assign oLongReady  = iRST_N && (r_count < C_DEPTH);
  assign w_pipe_req  = iPipeValid && (iPipeRd != 5'd0);
  // An x0 transfer still completes the handshake, it just never occupies a slot.
  assign w_push      = iLongValid && oLongReady && (iLongRd != 5'd0);
  assign w_pop       = !w_pipe_req && (r_count != '0);
  assign w_head_live = r_live[r_rd_ptr];
  assign w_wr_inc    = (r_wr_ptr == C_LAST) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_inc    = (r_rd_ptr == C_LAST) ? '0 : r_rd_ptr + 1'b1;

  // Per-entry state: push wins, a pop frees the slot, a pipeline write to the same rd kills it.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
        r_live[gi] <= 1'b0;
      end else if (w_push && (r_wr_ptr == PTRW'(gi))) begin
        r_live[gi]     <= 1'b1;
        r_ent_rd[gi]   <= iLongRd;
        r_ent_data[gi] <= iLongData;
      end else if (w_pop && (r_rd_ptr == PTRW'(gi))) begin
        r_live[gi] <= 1'b0;
      end else if (w_pipe_req && (r_ent_rd[gi] == iPipeRd)) begin
        r_live[gi] <= 1'b0;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= w_wr_inc;
      if (w_pop)  r_rd_ptr <= w_rd_inc;
      r_count <= r_count + {{PTRW{1'b0}}, w_push} - {{PTRW{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      oRegWrite      <= 1'b0;
      oWriteRegister <= 5'd0;
      oWriteData     <= 32'd0;
    end else if (w_pipe_req) begin
      oRegWrite      <= 1'b1;
      oWriteRegister <= iPipeRd;
      oWriteData     <= iPipeData;
    end else if (w_pop) begin
      oRegWrite <= w_head_live;
      if (w_head_live) begin
        oWriteRegister <= r_ent_rd[r_rd_ptr];
        oWriteData     <= r_ent_data[r_rd_ptr];
      end
    end else begin
      oRegWrite <= 1'b0;
    end
  end

  always_comb begin
    w_mask = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_live[i]) w_mask[r_ent_rd[i]] = 1'b1;
    end
  end

  assign oPendingMask = w_mask;

endmodule
